// File: rtl/booth_r8_pkg.sv
// Shared definitions for the radix-8 Booth multiplier.
// FSM states, multiple-select codes and digit-count helper.
package booth_r8_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      PRECOMP = 2'b01,
      SCAN    = 2'b10,
      FIN     = 2'b11
   } state_e;

   localparam logic [2:0] SEL_0 = 3'd0;
   localparam logic [2:0] SEL_1 = 3'd1;
   localparam logic [2:0] SEL_2 = 3'd2;
   localparam logic [2:0] SEL_3 = 3'd3;
   localparam logic [2:0] SEL_4 = 3'd4;

   function automatic int digits_for(input int width);
      return (width + 3) / 3;
   endfunction

endpackage

// File: rtl/booth_r8_recode.sv
// Radix-8 Booth digit recoder.
// Turns a 4-bit overlapping window into a magnitude select and sign.
module booth_r8_recode
   import booth_r8_pkg::*;
(
   input  logic [3:0] win_i,
   output logic [2:0] sel_o,
   output logic       neg_o
);

   // Window {y2,y1,y0,y-1} -> digit -4*y2 + 2*y1 + y0 + y-1
   always_comb begin
      sel_o = SEL_0;
      neg_o = 1'b0;
      case (win_i)
         4'h0, 4'hF: begin sel_o = SEL_0; neg_o = 1'b0; end
         4'h1, 4'h2: begin sel_o = SEL_1; neg_o = 1'b0; end
         4'h3, 4'h4: begin sel_o = SEL_2; neg_o = 1'b0; end
         4'h5, 4'h6: begin sel_o = SEL_3; neg_o = 1'b0; end
         4'h7:       begin sel_o = SEL_4; neg_o = 1'b0; end
         4'h8:       begin sel_o = SEL_4; neg_o = 1'b1; end
         4'h9, 4'hA: begin sel_o = SEL_3; neg_o = 1'b1; end
         4'hB, 4'hC: begin sel_o = SEL_2; neg_o = 1'b1; end
         4'hD, 4'hE: begin sel_o = SEL_1; neg_o = 1'b1; end
         default:    begin sel_o = SEL_0; neg_o = 1'b0; end
      endcase
   end

endmodule

// File: rtl/booth_r8_mult.sv
// Parametrised radix-8 Booth sequential multiplier.
// One Booth digit per clock, signed or unsigned per operation.
module booth_r8_mult
   import booth_r8_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic               mode_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic [2*WIDTH-1:0] product_o,
   output logic               done_o,
   output logic               busy_o,
   output logic [1:0]         state_o
);

   localparam int DIGITS = digits_for(WIDTH);
   localparam int MW     = WIDTH + 3;
   localparam int HW     = WIDTH + 4;
   localparam int YB     = 3 * DIGITS;
   localparam int YW     = YB + 1;
   localparam int AW     = HW + YB;
   localparam int EXT    = YB - WIDTH;
   localparam int CW     = $clog2(DIGITS + 1);
   localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

   state_e               state_q;
   logic [CW-1:0]        cnt_q;
   logic [WIDTH-1:0]     a_q;
   logic [WIDTH-1:0]     b_q;
   logic                 mode_q;
   logic [MW-1:0]        m_q;
   logic [HW-1:0]        m3_q;
   logic [YW-1:0]        y_q;
   logic [AW-1:0]        acc_q;
   logic [2*WIDTH-1:0]   prod_q;
   logic                 done_q;
   logic                 busy_q;

   logic [2:0]           sel;
   logic                 neg;
   logic [MW-1:0]        m_d;
   logic [HW-1:0]        m3_d;
   logic [YW-1:0]        y_init;
   logic [YW-1:0]        y_d;
   logic [HW-1:0]        m_x;
   logic [HW-1:0]        mag;
   logic [HW-1:0]        pp;
   logic [HW-1:0]        hi_sum;
   logic [AW-1:0]        acc_d;

   booth_r8_recode u_recode (
      .win_i (y_q[3:0]),
      .sel_o (sel),
      .neg_o (neg)
   );

   // Operand extension and hard 3M multiple from the latched inputs
   always_comb begin
      m_d    = mode_q ? {{3{a_q[WIDTH-1]}}, a_q} : {3'b000, a_q};
      m3_d   = {m_d[MW-1], m_d} + {m_d, 1'b0};
      y_init = {{EXT{mode_q & b_q[WIDTH-1]}}, b_q, 1'b0};
   end

   // Partial-product select, accumulate and 3-bit shift for one digit
   always_comb begin
      m_x = {m_q[MW-1], m_q};
      case (sel)
         SEL_1:   mag = m_x;
         SEL_2:   mag = m_x << 1;
         SEL_3:   mag = m3_q;
         SEL_4:   mag = m_x << 2;
         default: mag = '0;
      endcase
      pp     = neg ? (~mag + 1'b1) : mag;
      hi_sum = acc_q[AW-1 -: HW] + pp;
      acc_d  = {{3{hi_sum[HW-1]}}, hi_sum, acc_q[AW-HW-1:3]};
      y_d    = {{3{y_q[YW-1]}}, y_q[YW-1:3]};
   end

   // Control FSM with registered datapath and outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         mode_q  <= 1'b0;
         m_q     <= '0;
         m3_q    <= '0;
         y_q     <= '0;
         acc_q   <= '0;
         prod_q  <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start_i) begin
                  a_q     <= a_i;
                  b_q     <= b_i;
                  mode_q  <= mode_i;
                  busy_q  <= 1'b1;
                  state_q <= PRECOMP;
               end
            end
            PRECOMP: begin
               m_q     <= m_d;
               m3_q    <= m3_d;
               y_q     <= y_init;
               acc_q   <= '0;
               cnt_q   <= '0;
               state_q <= SCAN;
            end
            SCAN: begin
               acc_q <= acc_d;
               y_q   <= y_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  busy_q  <= 1'b0;
                  state_q <= FIN;
               end
            end
            FIN: begin
               prod_q  <= acc_q[2*WIDTH-1:0];
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign product_o = prod_q;
   assign done_o    = done_q;
   assign busy_o    = busy_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_booth_r8_mult.sv
// Self-checking bench for booth_r8_mult.
// Directed vectors on 16- and 8-bit instances plus random products.
module tb_booth_r8_mult;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   logic        start16, mode16, done16, busy16;
   logic [15:0] a16, b16;
   logic [31:0] p16;
   logic [1:0]  st16;

   logic        start8, mode8, done8, busy8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;
   logic [1:0]  st8;

   logic [3:0]  rwin;
   logic [2:0]  rsel;
   logic        rneg;

   int n_vec = 0;
   int n_err = 0;

   booth_r8_mult #(.WIDTH(16)) u_dut16 (
      .clk_i     (clk),
      .rst_i     (rst),
      .start_i   (start16),
      .mode_i    (mode16),
      .a_i       (a16),
      .b_i       (b16),
      .product_o (p16),
      .done_o    (done16),
      .busy_o    (busy16),
      .state_o   (st16)
   );

   booth_r8_mult #(.WIDTH(8)) u_dut8 (
      .clk_i     (clk),
      .rst_i     (rst),
      .start_i   (start8),
      .mode_i    (mode8),
      .a_i       (a8),
      .b_i       (b8),
      .product_o (p8),
      .done_o    (done8),
      .busy_o    (busy8),
      .state_o   (st8)
   );

   booth_r8_recode u_rec (
      .win_i (rwin),
      .sel_o (rsel),
      .neg_o (rneg)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic op16(input logic m, input logic [15:0] a,
                       input logic [15:0] b, output logic [31:0] p,
                       output int lat, output int bc);
      @(negedge clk);
      start16 = 1'b1; mode16 = m; a16 = a; b16 = b;
      @(posedge clk); #1;
      start16 = 1'b0; mode16 = ~m; a16 = ~a; b16 = ~b;
      lat = 0;
      bc = busy16 ? 1 : 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done16) begin lat = k; break; end
         if (busy16) bc++;
      end
      p = p16;
   endtask

   task automatic op8(input logic m, input logic [7:0] a,
                      input logic [7:0] b, output logic [15:0] p,
                      output int lat);
      @(negedge clk);
      start8 = 1'b1; mode8 = m; a8 = a; b8 = b;
      @(posedge clk); #1;
      start8 = 1'b0; mode8 = ~m; a8 = ~a; b8 = ~b;
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done8) begin lat = k; break; end
      end
      p = p8;
   endtask

   initial begin
      logic [31:0] p;
      logic [15:0] q;
      logic [31:0] exp32;
      logic signed [31:0] sa, sb;
      logic [15:0] ra, rb;
      logic        rm;
      int lat, bc, nd, d1, d2, dv;

      rst = 1'b1;
      start16 = 1'b0; mode16 = 1'b0; a16 = '0; b16 = '0;
      start8 = 1'b0; mode8 = 1'b0; a8 = '0; b8 = '0;
      rwin = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", 64'(st16), 64'h0);
      chk("rst_prod", 64'(p16), 64'h0);
      chk("rst_done", 64'(done16), 64'h0);
      chk("rst_busy", 64'(busy16), 64'h0);
      rst = 1'b0;

      for (int w = 0; w < 16; w++) begin
         rwin = 4'(w);
         #1;
         dv = -4 * int'(rwin[3]) + 2 * int'(rwin[2])
              + int'(rwin[1]) + int'(rwin[0]);
         chk("recode_sel", 64'(rsel), 64'(dv < 0 ? -dv : dv));
         chk("recode_neg", 64'(rneg), 64'(dv < 0));
      end

      op16(1'b1, 16'd3, 16'hFFFB, p, lat, bc);
      chk("s3xm5_prod", 64'(p), 64'hFFFFFFF1);
      chk("s3xm5_lat", 64'(lat), 64'd8);
      chk("s3xm5_busy", 64'(bc), 64'd7);
      @(posedge clk); #1;
      chk("done_pulse", 64'(done16), 64'h0);
      repeat (3) @(posedge clk);
      #1;
      chk("prod_hold", 64'(p16), 64'hFFFFFFF1);

      op16(1'b0, 16'hFFFF, 16'hFFFF, p, lat, bc);
      chk("u_ffff_sq", 64'(p), 64'hFFFE0001);
      op16(1'b1, 16'hFFFF, 16'hFFFF, p, lat, bc);
      chk("s_m1_sq", 64'(p), 64'h00000001);
      op16(1'b1, 16'h8000, 16'h8000, p, lat, bc);
      chk("s_min_sq", 64'(p), 64'h40000000);
      op16(1'b1, 16'h7FFF, 16'h8000, p, lat, bc);
      chk("s_max_min", 64'(p), 64'hC0008000);

      // start re-pulsed in SCAN must be ignored
      @(negedge clk);
      start16 = 1'b1; mode16 = 1'b1; a16 = 16'd3; b16 = 16'hFFFB;
      @(posedge clk); #1;
      start16 = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      start16 = 1'b1; mode16 = 1'b0; a16 = 16'd100; b16 = 16'd100;
      @(posedge clk); #1;
      start16 = 1'b0;
      nd = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (done16) nd++;
      end
      chk("repulse_ndone", 64'(nd), 64'd1);
      chk("repulse_prod", 64'(p16), 64'hFFFFFFF1);

      // start held high gives back-to-back operations
      @(negedge clk);
      start16 = 1'b1; mode16 = 1'b1; a16 = 16'd3; b16 = 16'd7;
      d1 = 0; d2 = 0;
      for (int k = 0; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done16) begin
            if (d1 == 0) d1 = k;
            else begin d2 = k; start16 = 1'b0; break; end
         end
      end
      start16 = 1'b0;
      chk("b2b_first", 64'(d1), 64'd8);
      chk("b2b_gap", 64'(d2 - d1), 64'd9);
      chk("b2b_prod", 64'(p16), 64'h15);

      // reset in the third SCAN cycle aborts the operation
      @(negedge clk);
      start16 = 1'b1; mode16 = 1'b0; a16 = 16'h1234; b16 = 16'h0042;
      @(posedge clk); #1;
      start16 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_state", 64'(st16), 64'h0);
      chk("abort_prod", 64'(p16), 64'h0);
      chk("abort_busy", 64'(busy16), 64'h0);
      rst = 1'b0;
      nd = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done16) nd++;
      end
      chk("abort_nodone", 64'(nd), 64'd0);
      op16(1'b1, 16'hFFF9, 16'd9, p, lat, bc);
      chk("after_abort", 64'(p), 64'hFFFFFFC1);
      chk("after_lat", 64'(lat), 64'd8);

      op8(1'b0, 8'hFF, 8'hFF, q, lat);
      chk("w8_u_ff_sq", 64'(q), 64'hFE01);
      chk("w8_lat", 64'(lat), 64'd5);
      op8(1'b1, 8'h80, 8'h80, q, lat);
      chk("w8_s_min_sq", 64'(q), 64'h4000);
      op8(1'b1, 8'h7F, 8'h80, q, lat);
      chk("w8_s_max_min", 64'(q), 64'hC080);

      for (int i = 0; i < 2000; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rm = 1'($urandom_range(0, 1));
         if (rm) begin
            sa = 32'($signed(ra));
            sb = 32'($signed(rb));
            exp32 = 32'(sa * sb);
         end else begin
            exp32 = {16'h0, ra} * {16'h0, rb};
         end
         op16(rm, ra, rb, p, lat, bc);
         chk("rand16", 64'(p), 64'(exp32));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
